lives_hud: RTL and testbench

Heads-up display renderer that sits directly downstream of the lives/invisibility tracker. It takes the tracker's `lives` count and `gameover` flag and draws a row of five 16x16 heart icons in the top-left of the arena. Full hearts show remaining lives and empty hearts show lost ones. A newly lost heart blinks for a fixed number of frames, and the whole row flashes once the game is over. Its `hud_on`/`hud_rgb` outputs feed the top-level pixel multiplexer at higher priority than the background colour.

---
 rtl/lives_hud.sv | 161 ++++++++++++++++
 tb/tb_lives_hud.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_hud.sv
// Lives HUD: draws a row of five 16x16 hearts from the tracker's lives count.
// Lost hearts blink for a while, and the whole row flashes after game over.
`timescale 1ns/1ps
module lives_hud #(
    parameter int HUD_X0       = 16,
    parameter int HUD_Y0       = 8,
    parameter int HUD_PITCH    = 20,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_HALF   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [2:0]  lives,
    input  logic        gameover,
    output logic        hud_on,
    output logic [11:0] hud_rgb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0]  HALF_LAST  = 8'(BLINK_HALF - 1);
    localparam logic [10:0] Y_TOP      = 11'(HUD_Y0);
    localparam logic [11:0] RGB_FULL   = 12'hF00;
    localparam logic [11:0] RGB_EMPTY  = 12'h444;
    localparam int          NUM_HEARTS = 5;

    state_t      state;
    logic [2:0]  disp_lives;
    logic [2:0]  blink_idx;
    logic [7:0]  frame_cnt;
    logic [7:0]  half_cnt;
    logic        phase;

    logic        decrement;
    logic        over_cond;
    logic        half_wrap;

    assign decrement = lives < disp_lives;
    assign over_cond = (lives == 3'd0) && gameover;
    assign half_wrap = (half_cnt == HALF_LAST);

    function automatic logic [15:0] heart_row(input logic [3:0] row);
        logic [15:0] bits;
        case (row)
            4'd1:    bits = 16'h1C38;
            4'd2:    bits = 16'h3E7C;
            4'd3:    bits = 16'h7FFE;
            4'd4:    bits = 16'h7FFE;
            4'd5:    bits = 16'h7FFE;
            4'd6:    bits = 16'h7FFE;
            4'd7:    bits = 16'h3FFC;
            4'd8:    bits = 16'h1FF8;
            4'd9:    bits = 16'h0FF0;
            4'd10:   bits = 16'h07E0;
            4'd11:   bits = 16'h03C0;
            4'd12:   bits = 16'h0180;
            default: bits = 16'h0000;
        endcase
        return bits;
    endfunction

    // All state moves only on frame_tick, so a frame is always drawn from one snapshot.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            disp_lives <= 3'd5;
            blink_idx  <= 3'd0;
            frame_cnt  <= 8'd0;
            half_cnt   <= 8'd0;
            phase      <= 1'b0;
        end else if (frame_tick) begin
            disp_lives <= lives;
            case (state)
                IDLE: begin
                    if (decrement) begin
                        state     <= BLINK;
                        blink_idx <= lives;
                        frame_cnt <= 8'd0;
                        half_cnt  <= 8'd0;
                        phase     <= 1'b0;
                    end else if (over_cond) begin
                        state <= OVER;
                    end
                end
                BLINK: begin
                    if (decrement) begin
                        blink_idx <= lives;
                        frame_cnt <= 8'd0;
                        half_cnt  <= 8'd0;
                        phase     <= 1'b0;
                    end else if (frame_cnt == FRAME_LAST) begin
                        state <= over_cond ? OVER : IDLE;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                        half_cnt  <= half_wrap ? 8'd0 : half_cnt + 8'd1;
                        if (half_wrap) phase <= ~phase;
                    end
                end
                OVER: begin
                    half_cnt <= half_wrap ? 8'd0 : half_cnt + 8'd1;
                    if (half_wrap) phase <= ~phase;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] left;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] row_bits;
    logic        in_rows;
    logic        mask_hit;
    logic        heart_full;
    logic        heart_drawn;

    // Hearts are at least 16 px apart, so at most one heart can claim a pixel.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x_w         = {1'b0, x};
        y_w         = {1'b0, y};
        left        = 11'd0;
        col         = 4'd0;
        mask_hit    = 1'b0;
        heart_full  = 1'b0;
        heart_drawn = 1'b0;
        in_rows     = (y_w >= Y_TOP) && (y_w <= Y_TOP + 11'd15);
        row         = 4'(y_w - Y_TOP);
        row_bits    = heart_row(row);
        for (int i = 0; i < NUM_HEARTS; i++) begin
            left = 11'(HUD_X0 + i * HUD_PITCH);
            if (in_rows && (x_w >= left) && (x_w <= left + 11'd15)) begin
                col         = 4'(x_w - left);
                mask_hit    = row_bits[4'd15 - col];
                heart_full  = (3'(i) < disp_lives);
                heart_drawn = 1'b1;
                if (state == BLINK && 3'(i) == blink_idx) heart_full = phase;
                if (state == OVER) begin
                    heart_full  = 1'b0;
                    heart_drawn = phase;
                end
            end
        end
    end

    assign hud_on  = video_on & mask_hit & heart_drawn;
    assign hud_rgb = hud_on ? (heart_full ? RGB_FULL : RGB_EMPTY) : 12'h000;

endmodule

// File: tb/tb_lives_hud.sv
// Self-checking bench for lives_hud: a rule-level model checked every cycle,
// plus hand-computed pixel expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_lives_hud;

    localparam int X0    = 16;
    localparam int Y0    = 8;
    localparam int PITCH = 20;
    localparam int NFR   = 60;
    localparam int NHALF = 8;
    localparam int M_IDLE  = 0;
    localparam int M_BLINK = 1;
    localparam int M_OVER  = 2;
    localparam int NPIX  = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        video_on = 1'b1;
    logic        frame_tick = 1'b0;
    logic [2:0]  lives = 3'd5;
    logic        gameover = 1'b0;
    logic        hud_on;
    logic [11:0] hud_rgb;

    int errors = 0;
    int checks = 0;

    lives_hud #(
        .HUD_X0(X0), .HUD_Y0(Y0), .HUD_PITCH(PITCH),
        .BLINK_FRAMES(NFR), .BLINK_HALF(NHALF)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .lives(lives), .gameover(gameover),
        .hud_on(hud_on), .hud_rgb(hud_rgb)
    );

    always #5 clk = ~clk;

    logic [15:0] mask_tbl [16] = '{16'h0000, 16'h1C38, 16'h3E7C, 16'h7FFE,
                                   16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h3FFC,
                                   16'h1FF8, 16'h0FF0, 16'h07E0, 16'h03C0,
                                   16'h0180, 16'h0000, 16'h0000, 16'h0000};

    int scan_x [NPIX] = '{17, 37, 57, 77, 97, 16, 24, 33, 113, 97, 103};
    int scan_y [NPIX] = '{11, 11, 11, 11, 11,  8, 12, 11,  11, 11,  20};
    bit scan_v [NPIX] = '{1,  1,  1,  1,  1,   1, 1,  1,   1,   0,  1};

    // Rule-level model of the display state
    int m_state = M_IDLE;
    int m_disp  = 5;
    int m_idx   = 0;
    int m_frame = 0;
    int m_half  = 0;
    bit m_phase = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= M_IDLE; m_disp <= 5; m_idx <= 0;
            m_frame <= 0; m_half <= 0; m_phase <= 1'b0;
        end else if (frame_tick) begin
            m_disp <= int'(lives);
            if (m_state != M_OVER && int'(lives) < m_disp) begin
                m_state <= M_BLINK; m_idx <= int'(lives);
                m_frame <= 0; m_half <= 0; m_phase <= 1'b0;
            end else if (m_state == M_BLINK && m_frame == NFR - 1) begin
                m_state <= (lives == 3'd0 && gameover) ? M_OVER : M_IDLE;
            end else if (m_state == M_IDLE) begin
                if (lives == 3'd0 && gameover) m_state <= M_OVER;
            end else begin
                if (m_state == M_BLINK) m_frame <= m_frame + 1;
                m_half <= (m_half + 1) % NHALF;
                if (m_half == NHALF - 1) m_phase <= !m_phase;
            end
        end
    end

    function automatic void expect_pix(input int px, input int py, input bit vo,
                                       output bit on, output logic [11:0] rgb);
        int hi, off, row;
        bit full, drawn;
        on = 1'b0;
        rgb = 12'h000;
        if (!vo || py < Y0 || py > Y0 + 15 || px < X0) return;
        hi  = (px - X0) / PITCH;
        off = (px - X0) % PITCH;
        if (hi > 4 || off > 15) return;
        row = py - Y0;
        if (((mask_tbl[row] >> (15 - off)) & 16'd1) == 16'd0) return;
        full  = (hi < m_disp);
        drawn = 1'b1;
        if (m_state == M_BLINK && hi == m_idx) full = m_phase;
        if (m_state == M_OVER) begin
            full  = 1'b0;
            drawn = m_phase;
        end
        if (!drawn) return;
        on  = 1'b1;
        rgb = full ? 12'hF00 : 12'h444;
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    bit          e_on;
    logic [11:0] e_rgb;

    always @(negedge clk) begin
        expect_pix(int'(x), int'(y), video_on, e_on, e_rgb);
        check("cyc_on", {11'b0, hud_on}, {11'b0, e_on});
        check("cyc_rgb", hud_rgb, e_rgb);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            for (int k = 0; k < NPIX; k++) begin
                x = 10'(scan_x[k]);
                y = 10'(scan_y[k]);
                video_on = scan_v[k];
                step();
            end
        end
        video_on = 1'b1;
    endtask

    task automatic pix(input string name, input int px, input int py, input logic vo,
                       input logic exp_on, input logic [11:0] exp_rgb);
        x = 10'(px);
        y = 10'(py);
        video_on = vo;
        #2;
        check({name, "_on"}, {11'b0, hud_on}, {11'b0, exp_on});
        check({name, "_rgb"}, hud_rgb, exp_rgb);
        step();
        video_on = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        pix("rst_h0", 17, 11, 1, 1, 12'hF00);
        pix("rst_h4", 97, 11, 1, 1, 12'hF00);
        pix("rst_row0", 16, 8, 1, 0, 12'h000);

        // Single loss, applied mid-frame
        lives = 3'd4;
        step();
        step();
        pix("pre_tick", 97, 11, 1, 1, 12'hF00);
        frames(1);
        pix("loss_f0", 97, 11, 1, 1, 12'h444);
        frames(7);
        pix("loss_f7", 97, 11, 1, 1, 12'h444);
        frames(1);
        pix("loss_f8", 97, 11, 1, 1, 12'hF00);
        frames(8);
        pix("loss_f16", 97, 11, 1, 1, 12'h444);
        frames(44);
        pix("loss_idle_h4", 97, 11, 1, 1, 12'h444);
        pix("loss_idle_h3", 77, 11, 1, 1, 12'hF00);
        frames(4);
        pix("loss_steady", 97, 11, 1, 1, 12'h444);

        // Increase follows with no blink
        lives = 3'd5;
        frames(1);
        pix("inc_h4", 97, 11, 1, 1, 12'hF00);

        // Loss during blink
        lives = 3'd4;
        frames(21);
        pix("mid_h3", 77, 11, 1, 1, 12'hF00);
        lives = 3'd3;
        frames(1);
        pix("drop_h4", 97, 11, 1, 1, 12'h444);
        pix("drop_h3", 77, 11, 1, 1, 12'h444);
        frames(8);
        pix("drop_h3_f8", 77, 11, 1, 1, 12'hF00);
        pix("drop_h4_f8", 97, 11, 1, 1, 12'h444);

        // Double loss in one frame
        frames(2);
        lives = 3'd1;
        frames(1);
        pix("dbl_h3", 77, 11, 1, 1, 12'h444);
        pix("dbl_h2", 57, 11, 1, 1, 12'h444);
        pix("dbl_h1", 37, 11, 1, 1, 12'h444);
        pix("dbl_h0", 17, 11, 1, 1, 12'hF00);
        frames(8);
        pix("dbl_h1_f8", 37, 11, 1, 1, 12'hF00);
        frames(52);
        pix("dbl_idle", 37, 11, 1, 1, 12'h444);

        // Game over: blink heart 0, then the whole row flashes
        lives = 3'd0;
        gameover = 1'b1;
        frames(1);
        pix("go_h0", 17, 11, 1, 1, 12'h444);
        frames(8);
        pix("go_f8", 17, 11, 1, 1, 12'hF00);
        frames(52);
        pix("over_h0", 17, 11, 1, 1, 12'h444);
        pix("over_h4", 97, 11, 1, 1, 12'h444);
        frames(5);
        pix("over_hidden", 17, 11, 1, 0, 12'h000);
        frames(8);
        pix("over_shown", 97, 11, 1, 1, 12'h444);
        frames(200);

        // Reset while in OVER
        reset = 1'b1;
        pix("rst_over_h4", 97, 11, 1, 1, 12'hF00);
        reset = 1'b0;

        // Reset at frame 30 of a blink
        frames(31);
        pix("b30_h0", 17, 11, 1, 1, 12'hF00);
        pix("b30_h1", 37, 11, 1, 1, 12'h444);
        reset = 1'b1;
        pix("rst_mid_h1", 37, 11, 1, 1, 12'hF00);
        pix("rst_mid_h4", 97, 11, 1, 1, 12'hF00);
        reset = 1'b0;
        lives = 3'd5;
        gameover = 1'b0;
        step();

        pix("vo_low", 17, 11, 0, 0, 12'h000);
        frames(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
